// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enum, the store byte-enable patterns and a helper that
// classifies a request as illegal (reserved size or misaligned address).
// ---------------------------------------------------------------------------
package lsu_pkg;

    // Access size encodings as they arrive on req_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Store byte-enable patterns; the single-byte pattern is shifted by the
    // byte offset to select the lane
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // A request is illegal when its size is reserved or its address is not
    // naturally aligned to that size
    function automatic logic is_illegal(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// ---------------------------------------------------------------------------
// lsu_lane_ext
// Picks the addressed byte or halfword lane out of a returned memory word and
// sign- or zero-extends it to 32 bits. Word accesses pass through unchanged.
//   rdata    in  32  word returned by the data memory
//   addr_lo  in  2   byte offset of the access within the word
//   size     in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   result   out 32  extended load value
// ---------------------------------------------------------------------------
module lsu_lane_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the lane named by the byte offset, then extend it according to
    // the access size and the signedness of the load
    always_comb begin
        lane_byte = 8'h00;
        lane_half = 16'h0000;
        result    = rdata;

        case (addr_lo)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase

        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = sign_ext ? {{24{lane_byte[7]}}, lane_byte}
                                       : {24'h000000, lane_byte};
            SZ_HALF: result = sign_ext ? {{16{lane_half[15]}}, lane_half}
                                       : {16'h0000, lane_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns byte/half/word load and store requests from the MEM stage into
// word-aligned data-memory accesses with byte enables, and returns extended
// load data (or an error) through a valid/ready response channel.
//   clk, reset                    clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready only when idle)
//   req_we, req_size, req_signed  access kind, size, load extension
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid / resp_ready       response handshake
//   resp_rdata, resp_err          extended load data, error flag
//   mem_en, mem_we, mem_addr,     one-cycle access strobe with byte enables,
//   mem_wdata                     word address and lane-replicated data
//   mem_rvalid, mem_rdata         returned read data
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    lsu_state_e        state_q,      state_d;
    logic              we_q,         we_d;
    logic [1:0]        size_q,       size_d;
    logic              signed_q,     signed_d;
    logic [31:0]       addr_q,       addr_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,   resp_err_d;

    logic [31:0]       load_result;

    lsu_lane_ext u_lane_ext (
        .rdata    (mem_rdata),
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .result   (load_result)
    );

    // State register plus the captured request, timeout counter and the
    // registered response; reset abandons whatever access is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= '0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic: illegal requests skip the memory entirely and go
    // straight to the response; loads wait for mem_rvalid with a bounded
    // counter; the response registers are cleared whenever a transaction
    // starts or retires so they read 0 outside RESP
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'h0;
                    if (is_illegal(req_size, req_addr[1:0])) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        resp_err_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_rdata_d = load_result;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: the memory port is only active during ISSUE, where the store
    // data is replicated into every lane so the byte enables alone choose
    // which bytes get written
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
        mem_en     = 1'b0;
        mem_we     = BE_NONE;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;

        if (state_q == ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
            case (size_q)
                SZ_BYTE: begin
                    mem_wdata = {4{wdata_q[7:0]}};
                    if (we_q) mem_we = BE_BYTE0 << addr_q[1:0];
                end
                SZ_HALF: begin
                    mem_wdata = {2{wdata_q[15:0]}};
                    if (we_q) mem_we = addr_q[1] ? BE_HALF_HI : BE_HALF_LO;
                end
                default: begin
                    mem_wdata = wdata_q;
                    if (we_q) mem_we = BE_WORD;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side counterpart of the immediate extender in the MIPS CPU. Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-aligned data-memory accesses with byte enables.
- On loads, extracts the addressed byte or halfword lane from the returned word and sign- or zero-extends it to 32 bits.
- Sits between the MEM stage and the data memory. Multi-cycle: the pipeline stalls while req_ready is low.

Parameters:
- MEM_TIMEOUT, 16: maximum WAIT cycles without mem_rvalid before a load is aborted with an error.
- CNT_W, 5: width of the timeout counter. Must hold MEM_TIMEOUT.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Unit can accept a request. High only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  Load extension: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  Byte address.
- req_wdata  in  32  Store data, right-aligned.
- resp_valid  out  1  Response present.
- resp_ready  in  1  Consumer accepts the response.
- resp_rdata  out  32  Extended load data. 0 for stores and on error.
- resp_err  out  1  Misaligned access, reserved size, or timeout.
- mem_en  out  1  Memory access strobe, one cycle per access.
- mem_we  out  4  Byte write enables. 0 for loads.
- mem_addr  out  32  Word address, {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  Lane-replicated store data.
- mem_rvalid  in  1  Read data valid.
- mem_rdata  in  32  Read word.

Behaviour:
- States and transitions:
  - IDLE: on req_valid && req_ready, capture we, size, signed, addr and wdata.
    - Illegal request goes to RESP with err = 1. Illegal means size = 3, size = 1 with addr[0] = 1, or size = 2 with addr[1:0] != 0.
    - Otherwise go to ISSUE.
  - ISSUE: one cycle. mem_en = 1; mem_addr, mem_we and mem_wdata are driven from the captured request. Timeout counter cleared.
    - Store: go to RESP.
    - Load: go to WAIT.
  - WAIT: loads only.
    - If mem_rvalid: extract and extend the lane, register it into resp_rdata, go to RESP.
    - Else if counter == MEM_TIMEOUT-1: set resp_err = 1, resp_rdata = 0, go to RESP.
    - Else: counter + 1.
  - RESP: resp_valid = 1, held with resp_rdata and resp_err stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- req_ready = (state == IDLE). There is no same-cycle pass-through: a new request is not accepted in the RESP handshake cycle.
- Latency:
  - Store: accept at edge 0, ISSUE during cycle 1, resp_valid from cycle 2.
  - Load with mem_rvalid in the first WAIT cycle: resp_valid from cycle 3.
  - Error response: resp_valid from cycle 1.
- Store lane rules:
  - byte: mem_we = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_we = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_we = 4'b1111; mem_wdata = wdata.
- Load lane rules:
  - byte: b = mem_rdata[8*addr[1:0] +: 8]; result = signed ? {{24{b[7]}}, b} : {24'b0, b}.
  - half: h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0]; extend to 32 bits the same way.
  - word: result = mem_rdata unchanged.
- Outside ISSUE: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- mem_rvalid outside WAIT is ignored.
- Illegal requests never assert mem_en.
- reset:
  - Takes effect at the next edge from any state, including mid-WAIT or mid-RESP. Any pending access is abandoned.
  - After reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, counter = 0.

Decomposition:
- Shared package lsu_pkg holds:
  - Size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - The state enum IDLE / ISSUE / WAIT / RESP.
  - The lane byte-enable constants.
- One combinational sub-module, lsu_lane_ext: inputs rdata, addr[1:0], size and signed; output is the 32-bit extended result. The FSM, counter and store packing stay in the top level.

Test Plan:
- lb, addr 0x1003, signed, mem_rdata 0x80FF_1234 on the first WAIT cycle -> mem_addr 0x1000, mem_we 0, resp_rdata 0xFFFF_FF80, resp_err 0, resp_valid at cycle 3.
- lhu, addr 0x2002, mem_rdata 0xBEEF_0001 -> resp_rdata 0x0000_BEEF. Same stimulus with lh -> 0xFFFF_BEEF.
- sb, addr 0x0001, wdata 0x1234_56AB -> single mem_en cycle, mem_we 4'b0010, mem_wdata 0xABAB_ABAB, resp_valid at cycle 2, resp_rdata 0.
- sh at addr 0x0003, then lw at 0x0002, then size = 3 -> each gives resp_err = 1 at cycle 1, and mem_en never rises.
- Load with mem_rvalid held low, MEM_TIMEOUT = 16 -> resp_err = 1, resp_rdata 0 after 16 WAIT cycles. A late mem_rvalid in IDLE has no effect.
- Two checks:
  - resp_ready held low for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0.
  - reset asserted mid-WAIT -> next cycle all outputs at reset values with req_ready = 1, and a following lw proceeds normally.
